// File: rtl/clk_phase_monitor_pkg.sv
// Shared definitions for the console clock phase monitor: FSM encodings,
// expected divider periods and the good-period rule.
package clk_phase_monitor_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCK  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   seen_edge;
    logic   sync_low;
  } dbg_t;

  localparam int unsigned PERIOD_SEVEN = 7;
  localparam int unsigned PERIOD_EIGHT = 8;

  // The /7 clock is DDR-generated, so its high phase legitimately lands on 3 or 4.
  function automatic logic period_good(input int unsigned period,
                                       input int unsigned high_len,
                                       input logic        expect_seven);
    if (expect_seven)
      return (period == PERIOD_SEVEN) && ((high_len == 3) || (high_len == 4));
    else
      return (period == PERIOD_EIGHT) && (high_len == 4);
  endfunction

endpackage

// File: rtl/clk_phase_monitor_if.sv
// Pin-side inputs and measurement results of the clock phase monitor.
interface clk_phase_monitor_if #(
  parameter int CNT_W = 4,
  parameter int ERR_W = 8
);
  import clk_phase_monitor_pkg::*;

  // No valid/ready handshake here: period_valid and sync_valid are single-cycle
  // strobes with no backpressure, and period/high_len/sync_phase hold their last value.
  logic             mon_clk;
  logic             mon_sync;
  logic             expect_seven;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_len;
  logic             period_valid;
  logic             locked;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] sync_phase;
  logic             sync_valid;
  dbg_t             dbg;

  modport master (
    output mon_clk, mon_sync, expect_seven, clear,
    input  period, high_len, period_valid, locked, err_count, sync_phase, sync_valid, dbg
  );

  modport slave (
    input  mon_clk, mon_sync, expect_seven, clear,
    output period, high_len, period_valid, locked, err_count, sync_phase, sync_valid, dbg
  );

endinterface

// File: rtl/clk_phase_monitor_sync_edge_det.sv
// Synchronizer chain for an asynchronous pin followed by a one-flop edge
// detector producing single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clkin,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/clk_phase_monitor.sv
// Measures an externally divided console clock against clkin: period, high
// time, lock status and the phase of the APU sync pulse.
module clk_phase_monitor
  import clk_phase_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int LOCK_COUNT  = 16,
  parameter int ERR_W       = 8
) (
  input  logic              clkin,
  input  logic              reset,
  clk_phase_monitor_if.slave bus
);

  localparam int               GOOD_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);

  logic              clk_rise, clk_fall;
  logic              sync_rise, sync_fall;
  logic [CNT_W-1:0]  run_cnt, run_cnt_next;
  logic              seen_edge, sync_low, expect_q;
  logic [CNT_W-1:0]  period_q, high_len_q, sync_phase_q;
  logic              period_valid_q, sync_valid_q;
  logic [ERR_W-1:0]  err_q;
  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d, good_inc;
  logic              period_measured, good, timeout, toggle, err_inc, sync_capture;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_clk_det (
    .clkin (clkin),
    .reset (reset),
    .pin   (bus.mon_clk),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_det (
    .clkin (clkin),
    .reset (reset),
    .pin   (bus.mon_sync),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  assign run_cnt_next    = clk_rise ? CNT_W'(1)
                         : ((run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_W'(1));
  assign timeout         = (run_cnt == CNT_MAX);
  assign period_measured = clk_rise & seen_edge;
  assign good            = period_good(32'(run_cnt), 32'(high_len_q), bus.expect_seven);
  assign toggle          = bus.expect_seven ^ expect_q;
  assign good_inc        = good_cnt_q + GOOD_W'(1);
  assign sync_capture    = sync_fall & (state_q == ST_LOCKED);

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      run_cnt        <= '0;
      seen_edge      <= 1'b0;
      period_q       <= '0;
      high_len_q     <= '0;
      period_valid_q <= 1'b0;
      sync_phase_q   <= '0;
      sync_valid_q   <= 1'b0;
      sync_low       <= 1'b0;
      expect_q       <= 1'b0;
      err_q          <= '0;
    end else begin
      run_cnt        <= run_cnt_next;
      period_valid_q <= period_measured;
      sync_valid_q   <= sync_capture;
      expect_q       <= bus.expect_seven;
      if (clk_rise)        seen_edge  <= 1'b1;
      if (period_measured) period_q   <= run_cnt;
      if (clk_fall)        high_len_q <= run_cnt;
      // Phase counts the rise cycle as 1; a sync landing on the rise itself reads 0.
      if (sync_capture)    sync_phase_q <= clk_rise ? '0 : run_cnt_next;
      if (sync_fall)       sync_low <= 1'b1;
      else if (sync_rise)  sync_low <= 1'b0;
      if (bus.clear)                         err_q <= '0;
      else if (err_inc && (err_q != ERR_MAX)) err_q <= err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_UNLOCK;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_inc    = 1'b0;
    if (toggle) begin
      // A mode change restarts acquisition and is not a lock loss.
      state_d    = ST_ACQUIRE;
      good_cnt_d = '0;
    end else begin
      case (state_q)
        ST_UNLOCK: begin
          if (clk_rise) begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = (period_measured && good) ? GOOD_W'(1) : '0;
          end
        end
        ST_ACQUIRE: begin
          if (period_measured) begin
            if (good) begin
              good_cnt_d = good_inc;
              if (good_inc == GOOD_TARGET) state_d = ST_LOCKED;
            end else begin
              good_cnt_d = '0;
            end
          end else if (timeout) begin
            state_d    = ST_UNLOCK;
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if ((period_measured && !good) || timeout) begin
            state_d    = ST_UNLOCK;
            good_cnt_d = '0;
            err_inc    = 1'b1;
          end
        end
        default: begin
          state_d    = ST_UNLOCK;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.high_len     = high_len_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.err_count    = err_q;
  assign bus.sync_phase   = sync_phase_q;
  assign bus.sync_valid   = sync_valid_q;
  assign bus.dbg          = '{state: state_q, seen_edge: seen_edge, sync_low: sync_low};

endmodule

// File: tb/tb_clk_phase_monitor.sv
// Directed bench for clk_phase_monitor: lock acquisition on /8 and /7 clocks,
// lock loss, timeout, clear precedence, sync phase capture and async reset.
module tb_clk_phase_monitor;
  import clk_phase_monitor_pkg::*;

  logic clkin;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pv_cnt   = 0;
  int   sv_cnt   = 0;
  int   pv_mark, sv_mark;

  clk_phase_monitor_if bus ();

  clk_phase_monitor dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // pulse counters sampled away from the active edge
  always @(negedge clkin) begin
    if (bus.period_valid === 1'b1) pv_cnt++;
    if (bus.sync_valid === 1'b1)   sv_cnt++;
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One monitored-clock period; sync_at >= 0 drops mon_sync for two cycles at that offset.
  task automatic mon_cycle(input int hi, input int lo, input int sync_at);
    for (int i = 0; i < hi + lo; i++) begin
      bus.mon_clk = (i < hi);
      if (sync_at >= 0) bus.mon_sync = !((i >= sync_at) && (i < sync_at + 2));
      tick();
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus.mon_clk      = 1'b0;
    bus.mon_sync     = 1'b1;
    bus.expect_seven = 1'b0;
    bus.clear        = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_period",    32'(bus.period), 0);
    check("rst_high_len",  32'(bus.high_len), 0);
    check("rst_locked",    32'(bus.locked), 0);
    check("rst_err",       32'(bus.err_count), 0);
    check("rst_sync_phase", 32'(bus.sync_phase), 0);
    check("rst_state",     32'(bus.dbg.state), 32'(ST_UNLOCK));
    reset = 1'b1;
    repeat (2) tick();

    // 1: /8 clock acquisition
    pv_mark = pv_cnt;
    mon_cycle(4, 4, -1);
    check("t1_first_edge_no_pv", 32'(pv_cnt - pv_mark), 0);
    check("t1_state_acquire",    32'(bus.dbg.state), 32'(ST_ACQUIRE));
    repeat (15) mon_cycle(4, 4, -1);
    check("t1_not_locked_15", 32'(bus.locked), 0);
    mon_cycle(4, 4, -1);
    check("t1_locked_16", 32'(bus.locked), 1);
    repeat (3) mon_cycle(4, 4, -1);
    check("t1_pv_count", 32'(pv_cnt - pv_mark), 19);
    check("t1_period",   32'(bus.period), 8);
    check("t1_high_len", 32'(bus.high_len), 4);

    // 2: /7 DDR clock, high alternating 3/4
    bus.expect_seven = 1'b1;
    tick();
    check("t2_toggle_acquire", 32'(bus.dbg.state), 32'(ST_ACQUIRE));
    check("t2_toggle_no_err",  32'(bus.err_count), 0);
    for (int i = 1; i <= 16; i++) mon_cycle((i % 2 == 1) ? 3 : 4, (i % 2 == 1) ? 4 : 3, -1);
    check("t2_not_locked_16", 32'(bus.locked), 0);
    mon_cycle(3, 4, -1);
    check("t2_locked_17", 32'(bus.locked), 1);
    check("t2_high_len_3", 32'(bus.high_len), 3);
    mon_cycle(4, 3, -1);
    check("t2_period",     32'(bus.period), 7);
    check("t2_high_len_4", 32'(bus.high_len), 4);
    check("t2_err",        32'(bus.err_count), 0);

    // 3: back to /8, then one 9-cycle period while locked
    bus.expect_seven = 1'b0;
    tick();
    check("t3_toggle_no_err", 32'(bus.err_count), 0);
    repeat (20) mon_cycle(4, 4, -1);
    check("t3_locked", 32'(bus.locked), 1);
    mon_cycle(4, 5, -1);
    mon_cycle(4, 4, -1);
    check("t3_unlock_bad", 32'(bus.locked), 0);
    check("t3_err_1",      32'(bus.err_count), 1);
    check("t3_period_9",   32'(bus.period), 9);
    repeat (15) mon_cycle(4, 4, -1);
    check("t3_not_relocked_15", 32'(bus.locked), 0);
    mon_cycle(4, 4, -1);
    check("t3_relocked_16", 32'(bus.locked), 1);

    // 4: stop mon_clk while locked; run_cnt saturates at 15
    repeat (9) tick();
    check("t4_locked_before_sat", 32'(bus.locked), 1);
    tick();
    check("t4_timeout_unlock", 32'(bus.locked), 0);
    check("t4_err_2",          32'(bus.err_count), 2);
    repeat (17) mon_cycle(4, 4, -1);
    check("t4_relocked", 32'(bus.locked), 1);
    repeat (9) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("t4_clear_unlock", 32'(bus.locked), 0);
    tick();
    check("t4_clear_wins", 32'(bus.err_count), 0);

    // 5: sync phase capture
    repeat (17) mon_cycle(4, 4, -1);
    check("t5_locked", 32'(bus.locked), 1);
    sv_mark = sv_cnt;
    mon_cycle(4, 4, 5);
    mon_cycle(4, 4, -1);
    check("t5_sync_pulse",  32'(sv_cnt - sv_mark), 1);
    check("t5_sync_phase6", 32'(bus.sync_phase), 6);
    check("t5_still_locked", 32'(bus.locked), 1);
    mon_cycle(4, 4, 0);
    mon_cycle(4, 4, -1);
    check("t5_coincide_pulse", 32'(sv_cnt - sv_mark), 2);
    check("t5_coincide_phase", 32'(bus.sync_phase), 0);
    bus.expect_seven = 1'b1;
    tick();
    check("t5_toggle_unlock", 32'(bus.locked), 0);
    check("t5_toggle_no_err", 32'(bus.err_count), 0);
    mon_cycle(4, 4, 5);
    mon_cycle(4, 4, -1);
    check("t5_unlocked_no_pulse", 32'(sv_cnt - sv_mark), 2);
    check("t5_unlocked_phase",    32'(bus.sync_phase), 0);

    // 6: async reset mid-period
    bus.expect_seven = 1'b0;
    tick();
    repeat (2) mon_cycle(4, 4, -1);
    check("t6_period_before", 32'(bus.period), 8);
    bus.mon_clk = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("t6_rst_period",   32'(bus.period), 0);
    check("t6_rst_high_len", 32'(bus.high_len), 0);
    check("t6_rst_state",    32'(bus.dbg.state), 32'(ST_UNLOCK));
    check("t6_rst_pv",       32'(bus.period_valid), 0);
    bus.mon_clk = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    pv_mark = pv_cnt;
    mon_cycle(4, 4, -1);
    check("t6_first_edge_no_pv", 32'(pv_cnt - pv_mark), 0);
    mon_cycle(4, 4, -1);
    check("t6_second_edge_pv", 32'(pv_cnt - pv_mark), 1);
    check("t6_period_8",       32'(bus.period), 8);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
